// File: rtl/matmul_edge_feeder_pkg.sv
// matmul_pkg: shared definitions for the matmul edge feeder.
//   DATA_W          - operand width of one lane (16 bits)
//   feeder_state_t  - feeder FSM states
//   lane_lsb()      - LSB position of lane i inside a packed N*DATA_W vector
package matmul_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    // Lane i occupies bits [DATA_W*i + DATA_W-1 : DATA_W*i].
    function automatic int lane_lsb(input int lane);
        return lane * DATA_W;
    endfunction

endpackage

// File: rtl/matmul_edge_feeder_if.sv
// matmul_edge_feeder_if: groups the feeder's control, operand-buffer and
// array-edge signals.
//   start, base_addr          - tile request from the controller
//   rd_en, rd_addr, rd_data   - operand buffer read port (1-cycle latency)
//   lane_valid, lane_data     - skewed lane streams to the array edge
//   reset_acc, busy, done     - accumulator clear and tile status
// Modports: master = the feeder, slave = its environment.
interface matmul_edge_feeder_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 8
);
    import matmul_pkg::*;

    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [N*DATA_W-1:0]   rd_data;
    logic [N-1:0]          lane_valid;
    logic [N*DATA_W-1:0]   lane_data;
    logic                  reset_acc;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, rd_data,
        output rd_en, rd_addr, lane_valid, lane_data, reset_acc, busy, done
    );

    modport slave (
        output start, base_addr, rd_data,
        input  rd_en, rd_addr, lane_valid, lane_data, reset_acc, busy, done
    );

endinterface

// File: rtl/matmul_edge_feeder_skew_delay.sv
// skew_delay: DEPTH-stage register line carrying {valid, DATA_W data}.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_data   - stage input
//   out_valid, out_data - output after DEPTH cycles (DEPTH=0: pass-through)
// Data registers load only when the incoming valid is set, so an idle line
// keeps presenting the last valid operand.
module skew_delay
    import matmul_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    genvar gi;

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are not needed for a zero-length line.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_line
            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic              v_in;
                logic [DATA_W-1:0] d_in;
                logic              v_reg;
                logic [DATA_W-1:0] d_reg;

                if (gi == 0) begin : g_first
                    assign v_in = in_valid;
                    assign d_in = in_data;
                end else begin : g_chain
                    assign v_in = g_stage[gi-1].v_reg;
                    assign d_in = g_stage[gi-1].d_reg;
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_reg <= 1'b0;
                        d_reg <= '0;
                    end else begin
                        v_reg <= v_in;
                        if (v_in) begin
                            d_reg <= d_in;
                        end
                    end
                end
            end
            assign out_valid = g_stage[DEPTH-1].v_reg;
            assign out_data  = g_stage[DEPTH-1].d_reg;
        end
    endgenerate

endmodule

// File: rtl/matmul_edge_feeder.sv
// matmul_edge_feeder: reads K operand vectors from the local buffer on a
// start pulse and streams them to one edge of the systolic array as N
// diagonally skewed lanes (lane i one cycle behind lane i-1). Issues a
// one-cycle accumulator clear before the first operand and pulses done once
// the array has drained.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - matmul_edge_feeder_if.master (start/base_addr, buffer read
//              port, lane outputs, reset_acc, busy, done)
// Build option: FEEDER_ZERO_PAD_EN forces lane_data to zero on lanes whose
// lane_valid is low; otherwise idle lanes hold their last operand.
module matmul_edge_feeder
    import matmul_pkg::*;
#(
    parameter int N         = 4,
    parameter int K         = 8,
    parameter int ADDR_W    = 8,
    parameter int DRAIN_CYC = 2*N+4
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_edge_feeder_if.master bus
);

    // DRAIN starts the cycle after the last read; the last lane-(N-1) valid
    // lands N-1 cycles later, so the whole drain phase is N + DRAIN_CYC long.
    localparam int DRAIN_LEN = N + DRAIN_CYC;
    localparam int CNT_MAX   = (DRAIN_LEN > K) ? DRAIN_LEN : K;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    feeder_state_t       state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                rd_pend_reg;
    logic [N*DATA_W-1:0] hold_reg;

    logic                rd_en;
    logic                reset_acc;
    logic                busy;
    logic                done;
    logic                stage0_valid;
    logic [N*DATA_W-1:0] stage0_data;
    logic [N-1:0]        lane_valid_w;
    logic [N*DATA_W-1:0] lane_data_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            rd_pend_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            rd_pend_reg <= rd_en;
            hold_reg    <= stage0_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        rd_en      = 1'b0;
        reset_acc  = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy     = 1'b0;
                cnt_next = '0;
                if (bus.start) begin
                    addr_next  = bus.base_addr;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                // Vector 0 is read alongside the accumulator clear.
                reset_acc = 1'b1;
                rd_en     = 1'b1;
                addr_next = addr_reg + 1'b1;
                if (K == 1) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next   = CNT_W'(1);
                    state_next = STREAM;
                end
            end
            STREAM: begin
                rd_en     = 1'b1;
                addr_next = addr_reg + 1'b1;
                if (cnt_reg == CNT_W'(K - 1)) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_reg == CNT_W'(DRAIN_LEN - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage 0: buffer data is valid the cycle after rd_en. Between reads the
    // last vector is replayed from hold_reg so lane 0 holds like the others.
    assign stage0_valid = rd_pend_reg;
    assign stage0_data  = rd_pend_reg ? bus.rd_data : hold_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic              v;
            logic [DATA_W-1:0] d;

            skew_delay #(.DEPTH(gi)) u_skew (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (stage0_valid),
                .in_data   (stage0_data[lane_lsb(gi) +: DATA_W]),
                .out_valid (v),
                .out_data  (d)
            );

            assign lane_valid_w[gi] = v;
`ifdef FEEDER_ZERO_PAD_EN
            assign lane_data_w[lane_lsb(gi) +: DATA_W] = v ? d : '0;
`else
            assign lane_data_w[lane_lsb(gi) +: DATA_W] = d;
`endif
        end
    endgenerate

    assign bus.rd_en      = rd_en;
    assign bus.rd_addr    = addr_reg;
    assign bus.lane_valid = lane_valid_w;
    assign bus.lane_data  = lane_data_w;
    assign bus.reset_acc  = reset_acc;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_matmul_edge_feeder.sv
// Testbench for matmul_edge_feeder: three instances (K=8, K=1, K=4) with
// N=4, ADDR_W=8 and the default drain length of 12 cycles.
module tb_matmul_edge_feeder;

    localparam int N     = 4;
    localparam int DRAIN = 2*N+4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    matmul_edge_feeder_if #(.N(N), .ADDR_W(8)) if8 ();
    matmul_edge_feeder_if #(.N(N), .ADDR_W(8)) if1 ();
    matmul_edge_feeder_if #(.N(N), .ADDR_W(8)) if4 ();

    matmul_edge_feeder #(.N(N), .K(8), .ADDR_W(8)) dut    (.clk(clk), .rst(rst), .bus(if8));
    matmul_edge_feeder #(.N(N), .K(1), .ADDR_W(8)) dut_k1 (.clk(clk), .rst(rst), .bus(if1));
    matmul_edge_feeder #(.N(N), .K(4), .ADDR_W(8)) dut_k4 (.clk(clk), .rst(rst), .bus(if4));

    // Buffer contents: lane i of word at address a = 0x0100 + (a-0x10) + i*0x1000.
    function automatic logic [63:0] word(input logic [7:0] a);
        logic [63:0] w;
        logic [7:0]  j;
        j = a - 8'h10;
        for (int i = 0; i < N; i++) begin
            w[i*16 +: 16] = 16'h0100 + {8'h00, j} + 16'(i * 16'h1000);
        end
        return w;
    endfunction

    // Operand buffers with 1-cycle read latency.
    always @(posedge clk or posedge rst) begin
        if (rst) if8.rd_data <= '0;
        else if (if8.rd_en) if8.rd_data <= word(if8.rd_addr);
    end
    always @(posedge clk or posedge rst) begin
        if (rst) if1.rd_data <= '0;
        else if (if1.rd_en) if1.rd_data <= word(if1.rd_addr);
    end
    always @(posedge clk or posedge rst) begin
        if (rst) if4.rd_data <= '0;
        else if (if4.rd_en) if4.rd_data <= word(if4.rd_addr);
    end

    typedef struct {
        logic        reset_acc;
        logic        rd_en;
        logic        chk_addr;
        logic [7:0]  rd_addr;
        logic [3:0]  valid;
        logic [63:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    typedef struct {
        logic        reset_acc;
        logic        rd_en;
        logic [7:0]  rd_addr;
        logic [3:0]  valid;
        logic [63:0] data;
        logic        busy;
        logic        done;
    } obs_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        case (sel)
            0: begin
                o.reset_acc = if8.reset_acc; o.rd_en = if8.rd_en; o.rd_addr = if8.rd_addr;
                o.valid = if8.lane_valid; o.data = if8.lane_data; o.busy = if8.busy; o.done = if8.done;
            end
            1: begin
                o.reset_acc = if1.reset_acc; o.rd_en = if1.rd_en; o.rd_addr = if1.rd_addr;
                o.valid = if1.lane_valid; o.data = if1.lane_data; o.busy = if1.busy; o.done = if1.done;
            end
            default: begin
                o.reset_acc = if4.reset_acc; o.rd_en = if4.rd_en; o.rd_addr = if4.rd_addr;
                o.valid = if4.lane_valid; o.data = if4.lane_data; o.busy = if4.busy; o.done = if4.done;
            end
        endcase
        return o;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       if8.start = v;
            1:       if1.start = v;
            default: if4.start = v;
        endcase
    endtask

    // Expected per-cycle outputs of one tile started at cycle 0, derived from
    // the documented timing. Lane holds start at 0 (fresh after reset).
    task automatic fill(input int k, input logic [7:0] base);
        logic [63:0] hold;
        logic [63:0] w;
        int          done_c;
        vec_t        v;
        hold   = '0;
        done_c = k + N + DRAIN + 1;
        tbl.delete();
        for (int c = 0; c <= done_c + 2; c++) begin
            v.reset_acc = (c == 1);
            v.rd_en     = (c >= 1 && c <= k);
            v.chk_addr  = v.rd_en;
            v.rd_addr   = base + 8'(c - 1);
            v.busy      = (c >= 1 && c <= done_c);
            v.done      = (c == done_c);
            v.valid     = '0;
            v.data      = '0;
            for (int i = 0; i < N; i++) begin
                if (c >= 2 + i && c <= k + 1 + i) begin
                    v.valid[i] = 1'b1;
                    w = word(base + 8'(c - 2 - i));
                    hold[i*16 +: 16] = w[i*16 +: 16];
                end
`ifdef FEEDER_ZERO_PAD_EN
                v.data[i*16 +: 16] = v.valid[i] ? hold[i*16 +: 16] : 16'h0000;
`else
                v.data[i*16 +: 16] = hold[i*16 +: 16];
`endif
            end
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input int sel, input string tag);
        obs_t o;
        @(posedge clk); #1;
        set_start(sel, 1'b1);
        foreach (tbl[c]) begin
            @(negedge clk);
            o = sample(sel);
            $display("%s c=%0d rst_acc=%b rd_en=%b addr=%h valid=%b data=%h busy=%b done=%b",
                     tag, c, o.reset_acc, o.rd_en, o.rd_addr, o.valid, o.data, o.busy, o.done);
            chk($sformatf("%s c%0d reset_acc", tag, c), 64'(o.reset_acc), 64'(tbl[c].reset_acc));
            chk($sformatf("%s c%0d rd_en", tag, c), 64'(o.rd_en), 64'(tbl[c].rd_en));
            if (tbl[c].chk_addr)
                chk($sformatf("%s c%0d rd_addr", tag, c), 64'(o.rd_addr), 64'(tbl[c].rd_addr));
            chk($sformatf("%s c%0d lane_valid", tag, c), 64'(o.valid), 64'(tbl[c].valid));
            chk($sformatf("%s c%0d lane_data", tag, c), o.data, tbl[c].data);
            chk($sformatf("%s c%0d busy", tag, c), 64'(o.busy), 64'(tbl[c].busy));
            chk($sformatf("%s c%0d done", tag, c), 64'(o.done), 64'(tbl[c].done));
            @(posedge clk); #1;
            set_start(sel, 1'b0);
        end
    endtask

    initial begin
        obs_t o;
        int   done_seen;
        rst = 1'b1;
        if8.start = 1'b0; if8.base_addr = 8'h10;
        if1.start = 1'b0; if1.base_addr = 8'h10;
        if4.start = 1'b0; if4.base_addr = 8'hFE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            $display("reset dut%0d valid=%b data=%h busy=%b", s, o.valid, o.data, o.busy);
            chk($sformatf("reset dut%0d outputs", s),
                {o.data[55:0], o.valid, o.rd_addr},
                64'h0);
            chk($sformatf("reset dut%0d ctrl", s),
                64'({o.data[63:56], o.reset_acc, o.rd_en, o.busy, o.done}), 64'h0);
        end
        rst = 1'b0;

        // Main tile: K=8, base 0x10, done at t+25.
        fill(8, 8'h10);
        run_table(0, "k8");
        // K=1: single read, one valid cycle per lane.
        fill(1, 8'h10);
        run_table(1, "k1");
        // K=4 with address wrap 0xFE,0xFF,0x00,0x01.
        fill(4, 8'hFE);
        run_table(2, "k4");

        // start held high: one tile, next accepted the cycle after done.
        @(posedge clk); #1;
        if8.start = 1'b1;
        done_seen = -1;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            o = sample(0);
            if (c <= 28) begin
                $display("held c=%0d rst_acc=%b busy=%b done=%b", c, o.reset_acc, o.busy, o.done);
                chk($sformatf("held c%0d reset_acc", c), 64'(o.reset_acc), 64'(c == 1 || c == 27));
                chk($sformatf("held c%0d busy", c), 64'(o.busy), 64'((c >= 1 && c <= 25) || c >= 27));
                chk($sformatf("held c%0d done", c), 64'(o.done), 64'(c == 25));
            end else if (o.done && done_seen < 0) begin
                done_seen = c;
            end
            @(posedge clk); #1;
            if (c == 28) if8.start = 1'b0;
        end
        $display("held second tile done at c=%0d", done_seen);
        chk("held second done cycle", 64'(done_seen), 64'(51));

        // Reset mid-stream at t+4.
        @(posedge clk); #1;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o = sample(0);
        chk("midrst pre lane_valid", 64'(o.valid), 64'(4'b0111));
        rst = 1'b1;
        #1;
        o = sample(0);
        $display("midrst valid=%b data=%h addr=%h busy=%b", o.valid, o.data, o.rd_addr, o.busy);
        chk("midrst lane_data", o.data, 64'h0);
        chk("midrst ctrl", 64'({o.rd_addr, o.valid, o.reset_acc, o.rd_en, o.busy, o.done}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            o = sample(0);
            chk($sformatf("postrst c%0d lane_valid", c), 64'(o.valid), 64'h0);
            chk($sformatf("postrst c%0d busy", c), 64'(o.busy), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
